// File: rtl/ac97_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ac97_cmd_seq
//  Description : AC97 codec register command sequencer. Issues one register
//                read/write per frame through slots 1/2 and collects the
//                status response for reads, with a frame-count timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ac97_cmd_seq #(
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic        ac97_bitclk,
    input  logic        ac97_rst,
    input  logic        ac97_strobe,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic [19:0] ac97_out_slot1,
    output logic [19:0] ac97_out_slot2,
    output logic        ac97_out_slot1_valid,
    output logic        ac97_out_slot2_valid,
    input  logic [19:0] ac97_in_slot1,
    input  logic [19:0] ac97_in_slot2,
    input  logic        ac97_in_slot1_valid,
    input  logic        ac97_in_slot2_valid,
    output logic        rsp_valid,
    output logic [6:0]  rsp_addr,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout
);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_ISSUE    = 2'd1;
    localparam logic [1:0] c_S_SENT     = 2'd2;
    localparam logic [1:0] c_S_WAIT_RSP = 2'd3;
    localparam logic [3:0] c_TIMEOUT_CNT = 4'(TIMEOUT_FRAMES);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_write;
    logic [6:0]  r_addr;
    logic [15:0] r_data;
    logic [3:0]  r_cnt;
    logic [19:0] r_slot1;
    logic [19:0] r_slot2;
    logic        r_slot1_valid;
    logic        r_slot2_valid;
    logic        r_rsp_valid;
    logic [6:0]  r_rsp_addr;
    logic [15:0] r_rsp_data;
    logic        r_rsp_timeout;

    logic        w_ready;
    logic        w_accept;
    logic        w_load;
    logic        w_clear;
    logic        w_hit;
    logic        w_expire;
    logic        w_cnt_step;
    logic        w_match;
    logic [3:0]  w_cnt_inc;
    logic        w_last_frame;
    logic        w_unused_ok;

    // Only the status address field and the top 16 data bits are meaningful.
    assign w_unused_ok = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

    assign w_match      = ac97_in_slot1_valid & ac97_in_slot2_valid &
                          (ac97_in_slot1[18:12] == r_addr);
    assign w_cnt_inc    = r_cnt + 4'd1;
    assign w_last_frame = (w_cnt_inc == c_TIMEOUT_CNT);

    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:     if (cmd_valid) w_state_nxt = c_S_ISSUE;
            c_S_ISSUE:    if (ac97_strobe) w_state_nxt = c_S_SENT;
            c_S_SENT:     if (ac97_strobe) w_state_nxt = r_write ? c_S_IDLE : c_S_WAIT_RSP;
            c_S_WAIT_RSP: if (ac97_strobe && (w_match || w_last_frame)) w_state_nxt = c_S_IDLE;
            default:      w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_ready    = 1'b0;
        w_accept   = 1'b0;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_hit      = 1'b0;
        w_expire   = 1'b0;
        w_cnt_step = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_ready  = 1'b1;
                w_accept = cmd_valid;
            end
            c_S_ISSUE: w_load  = ac97_strobe;
            c_S_SENT:  w_clear = ac97_strobe;
            c_S_WAIT_RSP: begin
                w_hit      = ac97_strobe & w_match;
                w_cnt_step = ac97_strobe & ~w_match;
                w_expire   = ac97_strobe & ~w_match & w_last_frame;
            end
            default: w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            r_write       <= 1'b0;
            r_addr        <= 7'd0;
            r_data        <= 16'd0;
            r_cnt         <= 4'd0;
            r_slot1       <= 20'd0;
            r_slot2       <= 20'd0;
            r_slot1_valid <= 1'b0;
            r_slot2_valid <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_addr    <= 7'd0;
            r_rsp_data    <= 16'd0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= w_hit | w_expire;
            if (w_accept) begin
                r_write <= cmd_write;
                r_addr  <= cmd_addr;
                r_data  <= cmd_data;
            end
            // Slot 1 bit 19 is the read flag, hence the inverted write bit.
            if (w_load) begin
                r_slot1       <= {~r_write, r_addr, 12'h000};
                r_slot1_valid <= 1'b1;
                r_slot2       <= r_write ? {r_data, 4'h0} : 20'h00000;
                r_slot2_valid <= r_write;
            end else if (w_clear) begin
                r_slot1       <= 20'd0;
                r_slot2       <= 20'd0;
                r_slot1_valid <= 1'b0;
                r_slot2_valid <= 1'b0;
            end
            if (w_clear) begin
                r_cnt <= 4'd0;
            end else if (w_cnt_step) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_hit) begin
                r_rsp_addr    <= r_addr;
                r_rsp_data    <= ac97_in_slot2[19:4];
                r_rsp_timeout <= 1'b0;
            end else if (w_expire) begin
                r_rsp_addr    <= r_addr;
                r_rsp_data    <= 16'd0;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready            = w_ready;
    assign ac97_out_slot1       = r_slot1;
    assign ac97_out_slot2       = r_slot2;
    assign ac97_out_slot1_valid = r_slot1_valid;
    assign ac97_out_slot2_valid = r_slot2_valid;
    assign rsp_valid            = r_rsp_valid;
    assign rsp_addr             = r_rsp_addr;
    assign rsp_data             = r_rsp_data;
    assign rsp_timeout          = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ac97_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ac97_cmd_seq
//  Description : Self-checking bench for ac97_cmd_seq with a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ac97_cmd_seq;

    localparam int T_FRAMES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [6:0]  cmd_addr = 7'd0;
    logic [15:0] cmd_data = 16'd0;
    logic [19:0] out_s1, out_s2;
    logic        out_v1, out_v2;
    logic [19:0] in_s1 = 20'd0, in_s2 = 20'd0;
    logic        in_v1 = 1'b0, in_v2 = 1'b0;
    logic        rsp_valid, rsp_timeout;
    logic [6:0]  rsp_addr;
    logic [15:0] rsp_data;

    logic [7:0]  fcnt = 8'd0;
    int          checks = 0;
    int          failures = 0;
    logic [6:0]  e_addr = 7'd0;
    logic [15:0] e_data = 16'd0;
    logic        e_to = 1'b0;

    always #5 clk = ~clk;
    always_ff @(posedge clk) fcnt <= fcnt + 8'd1;
    assign strobe = (fcnt == 8'd255);

    ac97_cmd_seq #(.TIMEOUT_FRAMES(T_FRAMES)) dut (
        .ac97_bitclk(clk), .ac97_rst(rst), .ac97_strobe(strobe),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .ac97_out_slot1(out_s1), .ac97_out_slot2(out_s2),
        .ac97_out_slot1_valid(out_v1), .ac97_out_slot2_valid(out_v2),
        .ac97_in_slot1(in_s1), .ac97_in_slot2(in_s2),
        .ac97_in_slot1_valid(in_v1), .ac97_in_slot2_valid(in_v2),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout)
    );

    // Inbound status: a valid response for address a, or one of three near-misses.
    task automatic drive_in(input bit match, input logic [6:0] a, input logic [15:0] d);
        int k;
        if (match) begin
            in_s1 = {1'($urandom), a, 12'($urandom)};
            in_s2 = {d, 4'($urandom)};
            in_v1 = 1'b1;
            in_v2 = 1'b1;
        end else begin
            k = $urandom_range(0, 2);
            in_s1 = {1'($urandom), a ^ 7'($urandom_range(1, 127)), 12'($urandom)};
            in_s2 = 20'($urandom);
            in_v1 = 1'b1;
            in_v2 = 1'b1;
            if (k == 1) begin in_s1[18:12] = a; in_v1 = 1'b0; end
            if (k == 2) begin in_s1[18:12] = a; in_v2 = 1'b0; end
        end
    endtask

    // One command: m = WAIT strobe (1-based) carrying the reply, 0 = never.
    task automatic run_txn(input logic w, input logic [6:0] a, input logic [15:0] d,
                           input int m, input bit at_strobe, input bit hold,
                           input logic nw, input logic [6:0] na, input logic [15:0] nd);
        int n, fin, guard;
        bit s, hit, done;
        logic [41:0] exp_slots, act_slots;
        logic [24:0] exp_rsp, act_rsp;
        hit = !w && m >= 1 && m <= T_FRAMES;
        fin = w ? 2 : 2 + (hit ? m : T_FRAMES);
        if (at_strobe) begin
            guard = 0;
            while (!(strobe && cmd_ready) && guard < 600) begin @(negedge clk); guard++; end
        end
        cmd_write = w; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 3000) begin
            drive_in(1'b1, a, 16'($urandom));
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL accept_wait got cmd_ready=%b exp=1 addr=%h", cmd_ready, a);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold) begin cmd_write = nw; cmd_addr = na; cmd_data = nd; end
        else cmd_valid = 1'b0;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            if (n == fin && !w) begin
                e_addr = a; e_data = hit ? d : 16'd0; e_to = !hit;
            end
            exp_slots = (n == 1) ? {{~w, a, 12'h000}, 1'b1, (w ? {d, 4'h0} : 20'h0), w} : 42'd0;
            act_slots = {out_s1, out_v1, out_s2, out_v2};
            exp_rsp   = {(!w && n == fin), e_to, e_addr, e_data};
            act_rsp   = {rsp_valid, rsp_timeout, rsp_addr, rsp_data};
            checks++;
            if (act_slots !== exp_slots) begin
                failures++;
                $display("FAIL slots n=%0d got=%h exp=%h", n, act_slots, exp_slots);
            end
            checks++;
            if (act_rsp !== exp_rsp) begin
                failures++;
                $display("FAIL rsp n=%0d got=%h exp=%h", n, act_rsp, exp_rsp);
            end
            checks++;
            if (cmd_ready !== (n == fin)) begin
                failures++;
                $display("FAIL cmd_ready n=%0d got=%b exp=%b", n, cmd_ready, (n == fin));
            end
            if (n == fin) begin
                done = 1'b1;
            end else begin
                s = strobe;
                if (s && n + 1 > 2) drive_in(!w && (n + 1 == m + 2), a, d);
                else drive_in(1'b1, a, 16'($urandom));
                @(negedge clk);
                if (s) n++;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL txn_timeout got n=%0d exp=%0d", n, fin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, out_s1, out_v1, out_s2, out_v2} !== {1'b1, 42'd0}) begin
            failures++;
            $display("FAIL reset_slots got=%h exp=%h", {cmd_ready, out_s1, out_v1, out_s2, out_v2}, {1'b1, 42'd0});
        end
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_addr, rsp_data} !== 25'd0) begin
            failures++;
            $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_timeout, rsp_addr, rsp_data});
        end
        rst = 1'b0;
        e_addr = 7'd0; e_data = 16'd0; e_to = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_write();
        repeat ($urandom_range(10, 120)) @(negedge clk);
        run_txn(1'b1, 7'h02, 16'h8000, 0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    endtask

    task automatic test_read();
        run_txn(1'b0, 7'h7C, 16'h5949, 1, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 7'h26, 16'hBEEF, 0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
        run_txn(1'b0, 7'h11, 16'h1234, T_FRAMES, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
        run_txn(1'b0, 7'h12, 16'h4321, T_FRAMES + 1, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    endtask

    task automatic test_strobe_accept();
        run_txn(1'b1, 7'($urandom), 16'($urandom), 0, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0);
        run_txn(1'b0, 7'($urandom), 16'($urandom), 2, 1'b1, 1'b0, 1'b0, 7'd0, 16'd0);
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [6:0] a;
        a = 7'($urandom);
        cmd_write = 1'b0; cmd_addr = a; cmd_data = 16'd0; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got=%b exp=1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!strobe && guard < 300) begin @(negedge clk); guard++; end
        @(negedge clk);
        repeat ($urandom_range(1, 50)) @(negedge clk);
        checks++;
        if (out_v1 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_sent got slot1_valid=%b exp=1", out_v1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e_addr = 7'd0; e_data = 16'd0; e_to = 1'b0;
        checks++;
        if ({cmd_ready, out_s1, out_v1, out_s2, out_v2, rsp_valid} !== {1'b1, 43'd0}) begin
            failures++;
            $display("FAIL rstmid_after got=%h exp=%h",
                     {cmd_ready, out_s1, out_v1, out_s2, out_v2, rsp_valid}, {1'b1, 43'd0});
        end
        for (int c = 0; c < 600; c++) begin
            drive_in(1'b1, a, 16'($urandom));
            @(negedge clk);
            checks++;
            if ({rsp_valid, out_v1, out_v2} !== 3'b000) begin
                failures++;
                $display("FAIL rstmid_quiet c=%0d got=%b exp=000", c, {rsp_valid, out_v1, out_v2});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] a2;
        logic [15:0] d2;
        a2 = 7'($urandom);
        d2 = 16'($urandom);
        run_txn(1'b1, 7'($urandom), 16'($urandom), 0, 1'b0, 1'b1, 1'b1, a2, d2);
        run_txn(1'b1, a2, d2, 0, 1'b0, 1'b1, 1'b0, 7'h55, 16'd0);
        run_txn(1'b0, 7'h55, 16'hC0DE, 3, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
        for (int c = 0; c < 520; c++) begin
            drive_in(1'b1, 7'h55, 16'($urandom));
            @(negedge clk);
            checks++;
            if ({cmd_ready, out_v1, out_v2, rsp_valid} !== 4'b1000) begin
                failures++;
                $display("FAIL b2b_idle c=%0d got=%b exp=1000", c, {cmd_ready, out_v1, out_v2, rsp_valid});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            run_txn(1'($urandom), 7'($urandom), 16'($urandom), $urandom_range(0, T_FRAMES + 1),
                    1'($urandom), 1'b0, 1'b0, 7'd0, 16'd0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_strobe_accept();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
